// File: rtl/frame_window_feeder.sv
// Sample stream to 5x8 sliding window for Core; optional clip via FEEDER_CLIP_EN.
// Latency: o_data/o_next 2 cycles after the last channel when no gap is pending.
// Backpressure: o_ready low from the last-channel accept until the window shift.
module frame_window_feeder #(
    parameter int                 N_CH       = 8,
    parameter int                 N_FR       = 5,
    parameter int                 GAP_CYCLES = 500,
    parameter logic signed [15:0] CLIP_MAX   = 16'sh1000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_valid,
    input  logic [15:0] i_sample,
    input  logic        i_sof,
    output logic        o_ready,
    input  logic        i_clear,
    output logic [15:0] o_data [0:N_FR*N_CH-1],
    output logic        o_next,
    output logic        o_primed,
    output logic        o_sync_err
);

    localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int FR_W  = $clog2(N_FR + 1);
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);
    localparam int N_WIN = N_FR * N_CH;
    localparam logic signed [15:0] CLIP_MIN = -CLIP_MAX;
`ifdef FEEDER_CLIP_EN
    localparam bit CLIP_EN = 1'b1;
`else
    localparam bit CLIP_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_FILL   = 2'd0,
        S_WAIT   = 2'd1,
        S_COMMIT = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CH_W-1:0]   r_ch;
    logic [FR_W-1:0]   r_frames;
    logic [FR_W-1:0]   w_frames_inc;
    logic [GAP_W-1:0]  r_gap;
    logic [15:0]       r_stage [0:N_CH-1];
    logic [15:0]       r_data  [0:N_WIN-1];
    logic              r_next;
    logic              r_primed;
    logic              r_sync_err;
    logic              w_accept;
    logic              w_commit;
    logic              w_resync;
    logic              w_last_ch;
    logic              w_gap_done;
    logic signed [15:0] w_s;
    logic [15:0]       w_clipped;
    logic [15:0]       w_sample;

    // Clip is purely combinational on the stage write, so it costs no cycles.
    assign w_s = signed'(i_sample);

    always_comb begin
        w_clipped = i_sample;
        if (w_s > CLIP_MAX) begin
            w_clipped = CLIP_MAX;
        end else if (w_s < CLIP_MIN) begin
            w_clipped = CLIP_MIN;
        end
    end

    assign w_sample     = CLIP_EN ? w_clipped : i_sample;
    assign w_resync     = i_sof && (r_ch != '0);
    assign w_last_ch    = (r_ch == CH_W'(N_CH - 1));
    assign w_frames_inc = (r_frames == FR_W'(N_FR)) ? r_frames : r_frames + FR_W'(1);
    // Counter reads 1 here and 0 during COMMIT, so the shift lands exactly GAP_CYCLES after o_next.
    assign w_gap_done   = (r_gap <= GAP_W'(1));

    always_ff @(posedge i_clk) begin
        if (i_rst_n || i_clear) begin
            r_state <= S_FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        o_ready     = 1'b0;
        w_accept    = 1'b0;
        w_commit    = 1'b0;
        case (r_state)
            S_FILL: begin
                o_ready  = 1'b1;
                w_accept = i_valid;
                if (i_valid && !w_resync && w_last_ch) begin
                    w_state_nxt = w_gap_done ? S_COMMIT : S_WAIT;
                end
            end
            S_WAIT: begin
                if (w_gap_done) begin
                    w_state_nxt = S_COMMIT;
                end
            end
            S_COMMIT: begin
                w_commit    = 1'b1;
                w_state_nxt = S_FILL;
            end
            default: begin
                w_state_nxt = S_FILL;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst_n) begin
            r_ch       <= '0;
            r_frames   <= '0;
            r_gap      <= '0;
            r_next     <= 1'b0;
            r_primed   <= 1'b0;
            r_sync_err <= 1'b0;
            for (int c = 0; c < N_CH; c++) begin
                r_stage[c] <= '0;
            end
            for (int i = 0; i < N_WIN; i++) begin
                r_data[i] <= '0;
            end
        end else if (i_clear) begin
            // Window contents are left as they are; they are meaningless until re-primed.
            r_ch       <= '0;
            r_frames   <= '0;
            r_gap      <= '0;
            r_next     <= 1'b0;
            r_primed   <= 1'b0;
            r_sync_err <= 1'b0;
        end else begin
            r_next     <= 1'b0;
            r_sync_err <= 1'b0;
            if (r_gap != '0) begin
                r_gap <= r_gap - GAP_W'(1);
            end
            if (w_accept) begin
                if (w_resync) begin
                    r_stage[0] <= w_sample;
                    r_ch       <= CH_W'(1);
                    r_sync_err <= 1'b1;
                end else begin
                    r_stage[r_ch] <= w_sample;
                    r_ch          <= w_last_ch ? '0 : r_ch + CH_W'(1);
                end
            end
            if (w_commit) begin
                for (int f = 0; f < N_FR - 1; f++) begin
                    for (int c = 0; c < N_CH; c++) begin
                        r_data[f*N_CH + c] <= r_data[(f+1)*N_CH + c];
                    end
                end
                for (int c = 0; c < N_CH; c++) begin
                    r_data[(N_FR-1)*N_CH + c] <= r_stage[c];
                end
                r_frames <= w_frames_inc;
                if (w_frames_inc == FR_W'(N_FR)) begin
                    r_next   <= 1'b1;
                    r_primed <= 1'b1;
                    r_gap    <= GAP_W'(GAP_CYCLES - 1);
                end
            end
        end
    end

    assign o_data     = r_data;
    assign o_next     = r_next;
    assign o_primed   = r_primed;
    assign o_sync_err = r_sync_err;

endmodule

// File: doc/frame_window_feeder.md
Name: frame_window_feeder

Overview:
- Producer side of the Core window interface: accepts a serial stream of 16-bit glove samples (8 channels per frame, channel 0 first) and assembles the 5-frame × 8-channel sliding window Core consumes on i_data.
- Issues the one-cycle next pulse Core expects once per committed frame, starting at the 5th frame.
- Enforces a minimum gap between pulses so Core finishes classifying before the window moves.
- Sits between the sensor/ADC front end and Core.

Parameters:
- N_CH, 8, channels per frame
- N_FR, 5, frames per window
- GAP_CYCLES, 500, minimum cycles from one o_next pulse to the next window update
- CLIP_MAX, 16'sh1000, symmetric clip limit (signed Q8.8, = 16.0); used only with FEEDER_CLIP_EN

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  synchronous reset, active-high (name kept per codebase, polarity is high)
- i_valid  in  1  sample valid
- i_sample  in  16  signed Q8.8 sample
- i_sof  in  1  marks the sample as channel 0 of a new frame
- o_ready  out  1  sample accepted when i_valid && o_ready
- i_clear  in  1  one-cycle pulse: empty the window (word done / restart)
- o_data  out  16 × [0:39]  window; o_data[f*8+c] = frame f (0 oldest, 4 newest), channel c
- o_next  out  1  one-cycle pulse: o_data updated, Core may start
- o_primed  out  1  window holds N_FR valid frames
- o_sync_err  out  1  one-cycle pulse: partial frame discarded

Behaviour:
- Reset (i_rst_n=1 at a clock edge): o_data all 0, o_next=0, o_sync_err=0, o_primed=0, o_ready=1, channel count=0, frame count=0, gap counter=0, state FILL.
- Staging register: 8 × 16. The accepted sample is written to stage[ch]; ch increments.
- FILL:
  - o_ready=1.
  - On the accept that writes ch=N_CH-1 (cycle T), go to COMMIT if gap counter==0, else WAIT.
- WAIT:
  - o_ready=0.
  - Gap counter decrements each cycle; go to COMMIT when it reaches 0.
- COMMIT (one cycle):
  - o_ready=0.
  - Window shifts: o_data[f*8+c] <= o_data[(f+1)*8+c] for f<4; o_data[32+c] <= stage[c].
  - Frame count saturates at N_FR.
  - If the post-update frame count == N_FR, o_next=1 in the following cycle and the gap counter loads GAP_CYCLES-1. Otherwise no pulse and no gap.
  - Return to FILL with ch=0.
- Latency:
  - Gap idle: o_data and o_next become valid 2 cycles after the accept of the last channel.
  - o_data is stable from its update until the next COMMIT, never mid-gap.
- o_primed = (frame count == N_FR), registered.
- i_sof on an accepted sample with ch≠0: discard the staged partial frame, write this sample to stage[0], set ch=1, pulse o_sync_err. i_sof with ch=0 is ignored.
- i_clear has priority over everything except reset:
  - Frame count=0, ch=0, gap counter=0, state FILL, o_primed=0, o_next suppressed.
  - o_data is not zeroed (old contents are don't-care until re-primed).
  - A sample presented in the same cycle is dropped.
- i_valid with o_ready=0: no accept; the upstream must hold the sample.
- Reset mid-frame or mid-gap: same as the reset values above; any pending o_next is lost.

Optional Feature:
- FEEDER_CLIP_EN defined: each sample is clipped before staging to [-CLIP_MAX, +CLIP_MAX], signed compare. This adds no cycles because the clip is combinational on the stage write.
- Undefined: samples pass through unchanged.

Test Plan:
- Reset, then 40 samples back to back, i_sof on every 8th, value = 16'h0100×frame + channel → o_next exactly once, 2 cycles after the 40th accept; o_data[0]=16'h0000, o_data[39]=16'h0407; o_primed=1.
- Continue with a 6th frame (16'h0500+c) immediately → o_ready drops after its last accept; COMMIT is delayed until 500 cycles after the previous o_next; o_data[0]=16'h0100, o_data[39]=16'h0507; second o_next spaced ≥500 cycles from the first.
- 3 samples, then a sample with i_sof=1 → o_sync_err pulse; the next 7 samples complete the frame; stage[0] holds the i_sof sample.
- Primed window, pulse i_clear mid-frame → o_primed=0, no o_next for the next 4 frames, o_next on the 5th.
- i_rst_n=1 during a WAIT gap → all outputs reach reset values the next cycle; no stale o_next.
- With FEEDER_CLIP_EN: input 16'h7FFF → staged 16'h1000; input 16'h8000 → 16'hF000. Without the macro: values pass unchanged.
